// File: rtl/sram_tdm_pkg.sv
// Shared definitions for the time-division SRAM arbiter: phase encoding,
// byte-lane width and default geometry.
`default_nettype none

package sram_tdm_pkg;

    localparam int LANE_W    = 8;
    localparam int AW_DEF    = 18;
    localparam int LANES_DEF = 4;
    localparam int GAW_DEF   = 14;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

endpackage

`default_nettype wire

// File: rtl/sram_lane_sel.sv
// Read-byte selector: returns the lowest-numbered selected lane of an SRAM
// word, with an empty select treated as lane 0.
`default_nettype none

module sram_lane_sel
    import sram_tdm_pkg::*;
#(
    parameter int LANES = LANES_DEF
) (
    input  logic [LANE_W*LANES-1:0] i_data,
    input  logic [LANES-1:0]        i_sel,
    output logic [LANE_W-1:0]       o_byte
);

    // Scanning downward lets the lowest set bit win; no bit set leaves lane 0.
    always_comb begin
        o_byte = i_data[LANE_W-1:0];
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_sel[i]) begin
                o_byte = i_data[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_tdm_mux.sv
// Four-phase SRAM time-division mux: P0 video fetch, P1..P3 one CPU slot.
// Optional macro SRAM_GPAGE_EN adds the I_GPAGE display-page input.
`default_nettype none

module sram_tdm_mux
    import sram_tdm_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int LANES = LANES_DEF,
    parameter int GAW   = GAW_DEF
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    output logic [AW-1:0]               O_SRAM_A,
    output logic [LANE_W-1:0]           O_SRAM_D,
    input  logic [LANE_W*LANES-1:0]     I_SRAM_D,
    output logic                        O_SRAM_OE,
    output logic                        O_SRAM_WE,
    output logic [LANES-1:0]            O_SRAM_BW,
    input  logic                        I_CREQ,
    input  logic                        I_CWE,
    input  logic [AW-1:0]               I_CADDR,
    input  logic [LANES-1:0]            I_CLANE,
    input  logic [LANE_W-1:0]           I_CD,
    output logic [LANE_W-1:0]           O_CD,
    output logic                        O_CACK,
    input  logic                        I_VEN,
    input  logic [GAW-1:0]              I_GA,
`ifdef SRAM_GPAGE_EN
    input  logic                        I_GPAGE,
`endif
    output logic [LANE_W*(LANES-1)-1:0] O_GD,
    output logic                        O_GVALID
);

    phase_e                        phase_q, phase_d;
    logic                          slot_q, slot_d;
    logic                          cwe_q, cwe_d;
    logic [AW-1:0]                 caddr_q, caddr_d;
    logic [LANES-1:0]              clane_q, clane_d;
    logic [LANE_W-1:0]             cd_q, cd_d;
    logic [LANE_W-1:0]             ocd_q, ocd_d;
    logic                          cack_q, cack_d;
    logic [LANE_W*(LANES-1)-1:0]   gd_q, gd_d;
    logic                          gvalid_q, gvalid_d;

    logic                          w_page;
    logic [AW-1:0]                 w_vaddr;
    logic [LANES-1:0]              w_lane_in;
    logic [LANE_W-1:0]             w_rd_byte;

`ifdef SRAM_GPAGE_EN
    assign w_page = I_GPAGE;
`else
    assign w_page = 1'b1;
`endif

    // Video window sits at the top of SRAM: ones above the page bit.
    always_comb begin
        w_vaddr             = '1;
        w_vaddr[GAW]        = w_page;
        w_vaddr[GAW-1:0]    = I_GA;
    end

    assign w_lane_in = (I_CLANE == '0) ? {{(LANES-1){1'b0}}, 1'b1} : I_CLANE;

    sram_lane_sel #(
        .LANES (LANES)
    ) u_lane_sel (
        .i_data (I_SRAM_D),
        .i_sel  (clane_q),
        .o_byte (w_rd_byte)
    );

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            phase_q <= P0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = P0;
        case (phase_q)
            P0: phase_d = P1;
            P1: phase_d = P2;
            P2: phase_d = P3;
            P3: phase_d = P0;
            default: phase_d = P0;
        endcase
    end

    always_comb begin
        slot_d   = slot_q;
        cwe_d    = cwe_q;
        caddr_d  = caddr_q;
        clane_d  = clane_q;
        cd_d     = cd_q;
        ocd_d    = ocd_q;
        cack_d   = 1'b0;
        gd_d     = gd_q;
        gvalid_d = 1'b0;
        case (phase_q)
            P0: begin
                if (I_VEN) begin
                    gd_d     = I_SRAM_D[LANE_W*LANES-1:LANE_W];
                    gvalid_d = 1'b1;
                end
            end
            P1: begin
                slot_d = I_CREQ;
                if (I_CREQ) begin
                    cwe_d   = I_CWE;
                    caddr_d = I_CADDR;
                    clane_d = w_lane_in;
                    cd_d    = I_CD;
                end
            end
            P2: begin
                // Read data is taken at the end of P2 so O_CD is valid with the ack.
                if (slot_q) begin
                    cack_d = 1'b1;
                    if (!cwe_q) begin
                        ocd_d = w_rd_byte;
                    end
                end
            end
            P3: slot_d = 1'b0;
            default: slot_d = 1'b0;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            slot_q   <= 1'b0;
            cwe_q    <= 1'b0;
            caddr_q  <= '0;
            clane_q  <= '0;
            cd_q     <= '0;
            ocd_q    <= '0;
            cack_q   <= 1'b0;
            gd_q     <= '0;
            gvalid_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            cwe_q    <= cwe_d;
            caddr_q  <= caddr_d;
            clane_q  <= clane_d;
            cd_q     <= cd_d;
            ocd_q    <= ocd_d;
            cack_q   <= cack_d;
            gd_q     <= gd_d;
            gvalid_q <= gvalid_d;
        end
    end

    // Bus is forced idle while reset is held, independent of the phase.
    always_comb begin
        O_SRAM_A  = '0;
        O_SRAM_D  = '0;
        O_SRAM_OE = 1'b0;
        O_SRAM_WE = 1'b0;
        O_SRAM_BW = '0;
        if (!I_RESET) begin
            case (phase_q)
                P0: begin
                    if (I_VEN) begin
                        O_SRAM_A  = w_vaddr;
                        O_SRAM_OE = 1'b1;
                        O_SRAM_BW = '1;
                    end
                end
                P1: begin
                    if (I_CREQ) begin
                        O_SRAM_A  = I_CADDR;
                        O_SRAM_BW = w_lane_in;
                        O_SRAM_OE = ~I_CWE;
                        O_SRAM_D  = I_CWE ? I_CD : '0;
                    end
                end
                P2, P3: begin
                    if (slot_q) begin
                        O_SRAM_A  = caddr_q;
                        O_SRAM_BW = clane_q;
                        O_SRAM_OE = ~cwe_q;
                        O_SRAM_D  = cwe_q ? cd_q : '0;
                        O_SRAM_WE = cwe_q && (phase_q == P2);
                    end
                end
                default: O_SRAM_A = '0;
            endcase
        end
    end

    assign O_CD     = ocd_q;
    assign O_CACK   = cack_q;
    assign O_GD     = gd_q;
    assign O_GVALID = gvalid_q;

endmodule

`default_nettype wire
